// File: rtl/sseg_pkg.sv
// Constants and FSM state type shared by the binary-to-BCD converter and the
// 7-segment display controller.
package sseg_pkg;

  localparam int DIGIT_W    = 4;
  localparam int DIGITS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decade.
module bcd_add3
  import sseg_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adj
);

  always_comb begin
    adj = digit;
    if (digit >= DIGIT_W'(5)) adj = digit + DIGIT_W'(3);
  end

endmodule

// File: rtl/bin2bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, with
// leading-zero blanking flags for the 7-segment display driver.
module bin2bcd_conv
  import sseg_pkg::*;
#(
  parameter int W      = 10,
  parameter int DIGITS = DIGITS_DEF
)
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [W-1:0]               bin,
  output logic                       busy,
  output logic                       done,
  output logic [DIGIT_W*DIGITS-1:0]  bcd,
  output logic [DIGITS-1:0]          blank
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(W + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  if (((64'd1 << W) - 64'd1) > (64'(10**DIGITS) - 64'd1)) begin : g_range_check
    $error("bin2bcd_conv: DIGITS too small to represent a W-bit value");
  end

  conv_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [BCD_W-1:0]  work_bcd;
  logic [BCD_W-1:0]  adj_bcd;
  logic [W-1:0]      work_bin;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_add3 u_add3 (
      .digit (work_bcd[i*DIGIT_W +: DIGIT_W]),
      .adj   (adj_bcd[i*DIGIT_W +: DIGIT_W])
    );
  end

  // Digit i is blanked only when it and every more significant digit are zero;
  // the ones digit is never blanked so a zero value still shows "0".
  function automatic logic [DIGITS-1:0] lead_blank(input logic [BCD_W-1:0] v);
    logic [DIGITS-1:0] r;
    logic              z;
    r = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z    = z & (v[i*DIGIT_W +: DIGIT_W] == '0);
      r[i] = z;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      work_bcd <= '0;
      work_bin <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      blank    <= BLANK_RST;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            work_bin <= bin;
            work_bcd <= '0;
            cnt      <= CNT_W'(W);
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // Adjusted digits and remaining binary shift together as one register.
          {work_bcd, work_bin} <= {adj_bcd, work_bin} << 1;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          bcd   <= work_bcd;
          blank <= lead_blank(work_bcd);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Scoreboard bench for bin2bcd_conv: directed conversions, ignored starts,
// mid-conversion reset and a back-to-back sweep of every 10-bit input.
module tb_bin2bcd_conv;

  localparam int W      = 10;
  localparam int DIGITS = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [W-1:0]      bin;
  logic              busy;
  logic              done;
  logic [15:0]       bcd;
  logic [3:0]        blank;

  logic [19:0] exp_q[$];
  int          n_cmp;
  int          n_fail;
  int          done_cnt;
  int          cyc;
  bit          spacing_en;

  bin2bcd_conv #(.W(W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .blank (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] ref_of(input int v);
    int d3, d2, d1, d0;
    logic [3:0] bl;
    d3 = v / 1000;
    d2 = (v / 100) % 10;
    d1 = (v / 10) % 10;
    d0 = v % 10;
    bl[3] = (d3 == 0);
    bl[2] = bl[3] && (d2 == 0);
    bl[1] = bl[2] && (d1 == 0);
    bl[0] = 1'b0;
    return {4'(d3), 4'(d2), 4'(d1), 4'(d0), bl};
  endfunction

  // Monitor: pops the scoreboard on every done pulse.
  initial begin
    logic [19:0] e;
    bit armed;
    int prev;
    cyc = 0; done_cnt = 0; armed = 0; prev = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst && done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_done: bcd=%h blank=%b with no conversion pending", bcd, blank);
        end else begin
          e = exp_q.pop_front();
          check("bcd", 32'(bcd), 32'(e[19:4]));
          check("blank", 32'(blank), 32'(e[3:0]));
        end
        if (spacing_en && armed) check("done_spacing", 32'(cyc - prev), 32'd12);
        armed = spacing_en;
        prev  = cyc;
      end
    end
  end

  // Called on a negedge: request a conversion at the next rising edge.
  task automatic launch(input int v, input logic [19:0] e);
    start = 1'b1;
    bin   = W'(v);
    exp_q.push_back(e);
  endtask

  // Returns edges from accept to the done cycle, and cycles with busy high.
  task automatic finish_conv(output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b0;
    bin   = W'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
      bin = W'($urandom);
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_bcd"}, 32'(bcd), 32'h0000);
    check({tag, "_blank"}, 32'(blank), 32'b1110);
  endtask

  initial begin
    int vals[10]          = '{0, 1023, 907, 45, 9, 100, 999, 10, 1000, 64};
    logic [15:0] ebcd[10] = '{16'h0000, 16'h1023, 16'h0907, 16'h0045, 16'h0009,
                              16'h0100, 16'h0999, 16'h0010, 16'h1000, 16'h0064};
    logic [3:0] ebl[10]   = '{4'b1110, 4'b0000, 4'b1000, 4'b1100, 4'b1110,
                              4'b1000, 4'b1000, 4'b1100, 4'b0000, 4'b1100};
    int lat, bcnt, base, l;

    n_cmp = 0; n_fail = 0; spacing_en = 0;
    rst = 1'b0; start = 1'b0; bin = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Directed values, each launched as soon as the previous done appears.
    foreach (vals[i]) begin
      launch(vals[i], {ebcd[i], ebl[i]});
      finish_conv(lat, bcnt);
      check("latency", 32'(lat), 32'd11);
      check("busy_cycles", 32'(bcnt), 32'd11);
    end
    repeat (3) @(negedge clk);

    // Starts during SHIFT (cycle 3) and during DONE (cycle 11) are dropped.
    base = done_cnt;
    launch(500, {16'h0500, 4'b1000});
    @(negedge clk);
    l = 0;
    while (!done && l < 40) begin
      start = (l == 2 || l == 10);
      if (start) bin = W'(12);
      @(negedge clk);
      l++;
    end
    start = 1'b0;
    check("ignored_latency", 32'(l), 32'd11);
    repeat (15) @(negedge clk);
    check("ignored_done_count", 32'(done_cnt - base), 32'd1);

    // Reset mid-conversion aborts without a done pulse.
    base = done_cnt;
    start = 1'b1; bin = W'(777);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort_assert");
    repeat (2) @(negedge clk);
    check_reset_outputs("abort_hold");
    rst = 1'b1;
    launch(64, {16'h0064, 4'b1100});
    finish_conv(lat, bcnt);
    check("post_reset_latency", 32'(lat), 32'd11);
    check("post_reset_done_count", 32'(done_cnt - base), 32'd1);
    repeat (3) @(negedge clk);

    // Back-to-back sweep of every input value.
    spacing_en = 1;
    for (int v = 0; v < 1024; v++) begin
      launch(v, ref_of(v));
      finish_conv(lat, bcnt);
    end
    spacing_en = 0;
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bin2bcd_conv.md
BIN2BCD_CONV -- requirements
Module: bin2bcd_conv

Interface
REQ-001 Parameter W, default 10, width of the binary input (JSTK2 axis value, 0..1023).
REQ-002 Parameter DIGITS, default 4, number of BCD digits produced.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-005 start  input  1  conversion request, sampled on the rising edge of clk.
REQ-006 bin  input  W  unsigned binary value, captured on the edge that accepts start.
REQ-007 busy  output  1  high from the accepting edge until the edge that ends the DONE state.
REQ-008 done  output  1  one-cycle pulse marking a new result on bcd/blank.
REQ-009 bcd  output  4*DIGITS  result with the thousands digit in [15:12] and the ones digit in [3:0]; held until the next done.
REQ-010 blank  output  DIGITS  leading-zero flags for the display driver, one per digit, aligned with bcd.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1: capture bin into the shift register, clear the BCD working register, load the iteration counter with W, and go to SHIFT.
REQ-013 In IDLE with start=0: stay in IDLE; bcd, blank and done=0 hold.
REQ-014 Each SHIFT cycle, step 1: add 3 to every working digit >= 5.
REQ-015 Each SHIFT cycle, step 2: shift {BCD, binary} left by one bit and decrement the counter.
REQ-016 SHIFT SHALL exit to DONE after exactly W iterations.
REQ-017 DONE SHALL load bcd and blank from the working register, drive done=1 for exactly one cycle, and return to IDLE.
REQ-018 Latency: done SHALL be high in the cycle beginning W+1 clock edges after the accepting edge (11 cycles for W=10).
REQ-019 start while busy=1, including the DONE cycle, SHALL be ignored and not queued.
REQ-020 A new start is accepted on the first edge with the FSM in IDLE; back-to-back conversions are therefore W+2 cycles apart.
REQ-021 blank[i] SHALL be 1 when digit i and all more significant digits are zero.
REQ-022 blank[0] SHALL always be 0, so value 0 displays a single "0".
REQ-023 bin SHALL be ignored except on the accepting edge.
REQ-024 Elaboration SHALL fail if 2**W-1 exceeds 10**DIGITS-1.

Reset
REQ-025 While rst=0, and immediately on its assertion, the block SHALL be in this state: FSM in IDLE, counter 0, working registers 0.
REQ-026 While rst=0, and immediately on its assertion, the outputs SHALL be: busy=0, done=0, bcd=0, blank = all digits except ones set (4'b1110).
REQ-027 Reset asserted mid-conversion SHALL abort it with no done pulse; the first edge after release SHALL be able to accept start.

Structure
REQ-028 The state enum, DIGITS default and digit width constant (4) SHALL live in the shared package sseg_pkg, reused by the display controller.
REQ-029 The per-digit add-3 adjust SHALL be a combinational sub-module bcd_add3, instantiated DIGITS times.
REQ-030 The block SHALL feed the 7-segment controller directly; no clock domain crossing.

Verification
REQ-031 bin=0, start pulse -> after 11 cycles, done pulse; bcd=16'h0000; blank=4'b1110.
REQ-032 bin=1023 -> bcd=16'h1023; blank=4'b0000; busy high for exactly 11 cycles.
REQ-033 bin=907 -> bcd=16'h0907, blank=4'b1000. bin=45 -> bcd=16'h0045, blank=4'b1100.
REQ-034 bin=500 accepted; start with bin=12 on cycles 3 and 11 -> both ignored; one done pulse with bcd=16'h0500.
REQ-035 Reset mid-conversion: bin=777 accepted, rst=0 at cycle 5 for 2 cycles -> no done pulse; outputs at reset values; next start with bin=64 -> bcd=16'h0064.
REQ-036 Exhaustive sweep 0..1023 with back-to-back starts -> every bcd matches the reference decimal value; done pulses exactly 12 cycles apart.
